// File: rtl/neuron_layer_driver.sv
// Layer sequencer for a serial neuron MAC: walks every neuron of a layer,
// fetches its weights and bias, issues one MAC operation per neuron and
// collects the results into a single vector offered under valid/ready.
module neuron_layer_driver #(
   parameter int NUM_INPUTS  = 8,
   parameter int NUM_NEURONS = 4,
   parameter int X_W         = 8,
   parameter int W_W         = 8,
   parameter int B_W         = 32,
   parameter int OUT_W       = 16,
   parameter int ADDR_W      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [NUM_INPUTS*X_W-1:0]    cmd_x_flat,
   input  logic [1:0]                   cmd_act_sel,
   input  logic [NUM_INPUTS-1:0]        cmd_mask,
   output logic                         prm_rd_en,
   output logic [ADDR_W-1:0]            prm_rd_addr,
   input  logic [NUM_INPUTS*W_W-1:0]    prm_rd_w,
   input  logic [B_W-1:0]               prm_rd_bias,
   output logic                         mac_in_valid,
   input  logic                         mac_in_ready,
   output logic [B_W-1:0]               mac_bias,
   output logic [NUM_INPUTS*X_W-1:0]    mac_x_flat,
   output logic [NUM_INPUTS*W_W-1:0]    mac_w_flat,
   output logic [1:0]                   mac_act_sel,
   output logic [NUM_INPUTS-1:0]        mac_mask_flat,
   input  logic                         mac_out_valid,
   input  logic [OUT_W-1:0]             mac_out_data,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [NUM_NEURONS*OUT_W-1:0] res_flat,
   output logic                         busy,
   output logic                         err_stray
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_FETCH       = 3'd1,
      S_WAIT_DATA   = 3'd2,
      S_ISSUE       = 3'd3,
      S_WAIT_RESULT = 3'd4,
      S_DONE        = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(NUM_NEURONS - 1);

   state_t                        state_q, state_d;
   logic [ADDR_W-1:0]             n_q, n_d;
   logic [ADDR_W-1:0]             addr_q, addr_d;
   logic [NUM_INPUTS*X_W-1:0]     x_q, x_d;
   logic [NUM_INPUTS*W_W-1:0]     w_q, w_d;
   logic [B_W-1:0]                bias_q, bias_d;
   logic [1:0]                    sel_q, sel_d;
   logic [NUM_INPUTS-1:0]         mask_q, mask_d;
   logic [NUM_NEURONS*OUT_W-1:0]  res_q, res_d;
   logic                          err_q, err_d;

   // Next-state, payload capture, result collection and stray detection.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      addr_d  = addr_q;
      x_d     = x_q;
      w_d     = w_q;
      bias_d  = bias_q;
      sel_d   = sel_q;
      mask_d  = mask_q;
      res_d   = res_q;

      // A result is only expected while waiting for one; anything else is stray.
      if (mac_out_valid && (state_q != S_WAIT_RESULT)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               x_d     = cmd_x_flat;
               sel_d   = cmd_act_sel;
               mask_d  = cmd_mask;
               res_d   = '0;
               n_d     = '0;
               addr_d  = '0;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            w_d     = prm_rd_w;
            bias_d  = prm_rd_bias;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (mac_in_ready) begin
               state_d = S_WAIT_RESULT;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT_RESULT: begin
            if (mac_out_valid) begin
               for (int k = 0; k < NUM_NEURONS; k++) begin
                  if (n_q == ADDR_W'(k)) begin
                     res_d[k*OUT_W +: OUT_W] = mac_out_data;
                  end else begin
                     res_d[k*OUT_W +: OUT_W] = res_q[k*OUT_W +: OUT_W];
                  end
               end
               if (n_q == LAST_N) begin
                  state_d = S_DONE;
               end else begin
                  n_d     = n_q + 1'b1;
                  addr_d  = n_q + 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_WAIT_RESULT;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         addr_q  <= '0;
         x_q     <= '0;
         w_q     <= '0;
         bias_q  <= '0;
         sel_q   <= 2'b00;
         mask_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         x_q     <= x_d;
         w_q     <= w_d;
         bias_q  <= bias_d;
         sel_q   <= sel_d;
         mask_q  <= mask_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign prm_rd_en     = (state_q == S_FETCH);
   assign prm_rd_addr   = addr_q;
   assign mac_in_valid  = (state_q == S_ISSUE);
   assign res_valid     = (state_q == S_DONE);
   assign mac_bias      = bias_q;
   assign mac_x_flat    = x_q;
   assign mac_w_flat    = w_q;
   assign mac_act_sel   = sel_q;
   assign mac_mask_flat = mask_q;
   assign res_flat      = res_q;
   assign err_stray     = err_q;

endmodule
